// File: rtl/noc_params.sv
// Shared NoC types: flit format, flit labels and the crossbar output-port lock state.
package noc_params;

  localparam int VC_SIZE          = 2;
  localparam int DEST_ADDR_SIZE_X = 3;
  localparam int DEST_ADDR_SIZE_Y = 3;
  localparam int PAYLOAD_SIZE     = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [PAYLOAD_SIZE-1:0]     data;
  } flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } xbar_state_t;

endpackage

// File: rtl/crossbar_st_port.sv
// One crossbar output: input mux, packet lock FSM, output register and sticky error.
// With XBAR_STATS_EN defined, also a saturating forwarded-flit counter.
//
// state | meaning
// IDLE  | no packet in flight; HEAD locks, HEADTAIL passes, BODY/TAIL are errors
// BUSY  | locked to input 'owner' until its TAIL (or an erroneous HEADTAIL)
module crossbar_st_port
  import noc_params::*;
#(
  parameter int INPUT_NUM = 5,
`ifdef XBAR_STATS_EN
  parameter int CNT_W = 16,
`endif
  localparam int SEL_SIZE = $clog2(INPUT_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  flit_t                data_i [INPUT_NUM],
  input  logic [INPUT_NUM-1:0] valid_i,
  input  logic [SEL_SIZE-1:0]  sel_i,
  input  logic                 sel_valid_i,
  output flit_t                data_o,
  output logic                 valid_o,
  output logic                 error_o
`ifdef XBAR_STATS_EN
  ,
  output logic [CNT_W-1:0]     flit_cnt_o
`endif
);

  xbar_state_t         state;
  logic [SEL_SIZE-1:0] owner;
  flit_t               pick;
  logic                pick_valid;
  logic                hit;
  logic                bad_sel;
  logic                req;
  logic                own;
  logic                fwd;

  // A select that matches no input index is out of range.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    hit        = 1'b0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (sel_i == SEL_SIZE'(i)) begin
        pick       = data_i[i];
        pick_valid = valid_i[i];
        hit        = 1'b1;
      end
    end
  end

  assign bad_sel = sel_valid_i & ~hit;
  assign req     = sel_valid_i & hit & pick_valid;
  assign own     = (sel_i == owner);
  assign fwd     = req & ((state == IDLE) | own);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      valid_o <= fwd;
      if (fwd) data_o <= pick;
      if (bad_sel) error_o <= 1'b1;
      if (req) begin
        unique case (state)
          IDLE: begin
            unique case (pick.flit_label)
              HEAD: begin
                state <= BUSY;
                owner <= sel_i;
              end
              HEADTAIL: state   <= IDLE;
              BODY:     error_o <= 1'b1;
              TAIL:     error_o <= 1'b1;
            endcase
          end
          BUSY: begin
            if (!own) begin
              error_o <= 1'b1;
            end else begin
              unique case (pick.flit_label)
                BODY: state   <= BUSY;
                TAIL: state   <= IDLE;
                HEAD: error_o <= 1'b1;
                HEADTAIL: begin
                  error_o <= 1'b1;
                  state   <= IDLE;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

`ifdef XBAR_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_cnt_o <= '0;
    end else if (fwd && (flit_cnt_o != '1)) begin
      flit_cnt_o <= flit_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/crossbar_st.sv
// Registered packet-aware switch-traversal crossbar: fans inputs and selects out to
// one crossbar_st_port per output. XBAR_STATS_EN adds per-output flit counters.
module crossbar_st
  import noc_params::*;
#(
  parameter int INPUT_NUM  = 5,
  parameter int OUTPUT_NUM = 5,
`ifdef XBAR_STATS_EN
  parameter int CNT_W = 16,
`endif
  localparam int SEL_SIZE = $clog2(INPUT_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  flit_t                 data_i      [INPUT_NUM],
  input  logic [INPUT_NUM-1:0]  valid_i,
  input  logic [SEL_SIZE-1:0]   sel_i       [OUTPUT_NUM],
  input  logic [OUTPUT_NUM-1:0] sel_valid_i,
  output flit_t                 data_o      [OUTPUT_NUM],
  output logic [OUTPUT_NUM-1:0] valid_o,
  output logic [OUTPUT_NUM-1:0] error_o
`ifdef XBAR_STATS_EN
  ,
  output logic [CNT_W-1:0]      flit_cnt_o  [OUTPUT_NUM]
`endif
);

  for (genvar o = 0; o < OUTPUT_NUM; o++) begin : g_port
    crossbar_st_port #(
      .INPUT_NUM(INPUT_NUM)
`ifdef XBAR_STATS_EN
      ,
      .CNT_W(CNT_W)
`endif
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .sel_i      (sel_i[o]),
      .sel_valid_i(sel_valid_i[o]),
      .data_o     (data_o[o]),
      .valid_o    (valid_o[o]),
      .error_o    (error_o[o])
`ifdef XBAR_STATS_EN
      ,
      .flit_cnt_o (flit_cnt_o[o])
`endif
    );
  end

endmodule

// File: tb/tb_crossbar_st.sv
// Scoreboard bench for crossbar_st: directed vectors push expected outputs, a
// negedge monitor pops and compares. Counter saturation runs under XBAR_STATS_EN.
module tb_crossbar_st;
  import noc_params::*;

  localparam int NI = 5;
  localparam int NO = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  flit_t         data_i [NI];
  logic [NI-1:0] valid_i;
  logic [SW-1:0] sel_i [NO];
  logic [NO-1:0] sel_valid_i;
  flit_t         data_o [NO];
  logic [NO-1:0] valid_o;
  logic [NO-1:0] error_o;
`ifdef XBAR_STATS_EN
  logic [3:0]    flit_cnt_o [NO];
`endif

  crossbar_st #(
    .INPUT_NUM (NI),
    .OUTPUT_NUM(NO)
`ifdef XBAR_STATS_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .sel_i      (sel_i),
    .sel_valid_i(sel_valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .error_o    (error_o)
`ifdef XBAR_STATS_EN
    ,
    .flit_cnt_o (flit_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic [NO-1:0]   fwd;
    logic [NO-1:0]   err;
    flit_t [NO-1:0]  data;
  } rec_t;

  rec_t sb[$];
  rec_t mon_r;
  int   errors = 0;
  int   checks = 0;

  flit_t          nx_data [NI];
  logic [NI-1:0]  nx_valid;
  logic [SW-1:0]  nx_sel [NO];
  logic [NO-1:0]  nx_sv;
  flit_t [NO-1:0] exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input int vc, input int x, input int y,
                               input logic [15:0] p);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_SIZE'(vc);
    f.x_dest     = DEST_ADDR_SIZE_X'(x);
    f.y_dest     = DEST_ADDR_SIZE_Y'(y);
    f.data       = p;
    return f;
  endfunction

  task automatic clear();
    nx_valid = '0;
    nx_sv    = '0;
    for (int i = 0; i < NI; i++) nx_data[i] = '0;
    for (int o = 0; o < NO; o++) nx_sel[o] = '0;
  endtask

  task automatic put(input int i, input flit_t f);
    nx_data[i]  = f;
    nx_valid[i] = 1'b1;
  endtask

  task automatic route(input int o, input int i);
    nx_sel[o] = SW'(i);
    nx_sv[o]  = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) data_i[i] = nx_data[i];
    for (int o = 0; o < NO; o++) sel_i[o] = nx_sel[o];
    valid_i     = nx_valid;
    sel_valid_i = nx_sv;
  endtask

  // fwd/err are the hand-derived valid_o and sticky error_o expected one cycle later.
  task automatic issue(input logic [NO-1:0] fwd, input logic [NO-1:0] err);
    rec_t r;
    @(posedge clk);
    #1;
    drive();
    for (int o = 0; o < NO; o++)
      if (fwd[o]) exp_data[o] = nx_data[nx_sel[o]];
    r.due  = cyc + 1;
    r.fwd  = fwd;
    r.err  = err;
    r.data = exp_data;
    sb.push_back(r);
    clear();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_valid_o", 32'(valid_o), 32'(0));
    check("rst_error_o", 32'(error_o), 32'(0));
    for (int o = 0; o < NO; o++) begin
      check($sformatf("rst_data_o[%0d]", o), 32'(data_o[o]), 32'(0));
      exp_data[o] = '0;
    end
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_r = sb.pop_front();
      if (mon_r.due != cyc) check("sb_timing", 32'(cyc), 32'(mon_r.due));
      check("valid_o", 32'(valid_o), 32'(mon_r.fwd));
      check("error_o", 32'(error_o), 32'(mon_r.err));
      for (int o = 0; o < NO; o++)
        check($sformatf("data_o[%0d]", o), 32'(data_o[o]), 32'(mon_r.data[o]));
    end
  end

  initial begin
    clear();
    drive();
    for (int o = 0; o < NO; o++) exp_data[o] = '0;
    #2;
    check("init_valid_o", 32'(valid_o), 32'(0));
    check("init_error_o", 32'(error_o), 32'(0));
    check("init_data_o0", 32'(data_o[0]), 32'(0));
    #10;
    rst = 1'b1;

    // Straight-through HEADTAIL on every port, then an idle cycle (data must hold).
    for (int i = 0; i < NI; i++) begin
      put(i, mk(HEADTAIL, 1, 1, 1, 16'h1000 + 16'(i)));
      route(i, i);
    end
    issue(5'b11111, 5'b00000);
    issue(5'b00000, 5'b00000);

    // Out2 locked to in3; intruding in1 BODY is dropped and flagged.
    put(3, mk(HEAD, 2, 2, 0, 16'h3001));     route(2, 3); issue(5'b00100, 5'b00000);
    put(1, mk(BODY, 0, 0, 0, 16'h1bad));
    put(3, mk(BODY, 2, 2, 0, 16'h30ff));     route(2, 1); issue(5'b00000, 5'b00100);
    put(3, mk(BODY, 2, 2, 0, 16'h3002));     route(2, 3); issue(5'b00100, 5'b00100);
    put(3, mk(TAIL, 2, 2, 0, 16'h3003));     route(2, 3); issue(5'b00100, 5'b00100);
    put(0, mk(HEADTAIL, 0, 1, 2, 16'h0a0a)); route(2, 0); issue(5'b00100, 5'b00100);

    // Multicast of in1 to out0 and out4.
    put(1, mk(HEADTAIL, 3, 4, 2, 16'hbeef));
    route(0, 1); route(4, 1);
    issue(5'b10001, 5'b00100);

    // Out-of-range select, then out1 still idle; valid_i low means no request.
    put(1, mk(HEAD, 1, 1, 1, 16'h7777));     route(1, 7); issue(5'b00000, 5'b00110);
    put(2, mk(HEADTAIL, 0, 5, 6, 16'h2222)); route(1, 2); issue(5'b00010, 5'b00110);
    route(0, 2);                                          issue(5'b00000, 5'b00110);

    // Reset mid-packet on out3, then BODY in IDLE is an error.
    put(4, mk(HEAD, 1, 3, 3, 16'h4001)); route(3, 4); issue(5'b01000, 5'b00110);
    put(4, mk(BODY, 1, 3, 3, 16'h4002)); route(3, 4); issue(5'b01000, 5'b00110);
    pulse_reset();
    put(4, mk(BODY, 1, 3, 3, 16'h4003)); route(3, 4); issue(5'b01000, 5'b01000);

    // After another reset a fresh packet runs cleanly, then lock-violation paths.
    pulse_reset();
    put(4, mk(HEAD, 2, 3, 3, 16'h4004));     route(3, 4); issue(5'b01000, 5'b00000);
    put(4, mk(TAIL, 2, 3, 3, 16'h4005));     route(3, 4); issue(5'b01000, 5'b00000);
    put(4, mk(HEAD, 2, 3, 3, 16'h4006));     route(3, 4); issue(5'b01000, 5'b00000);
    put(4, mk(HEAD, 2, 3, 3, 16'h4007));     route(3, 4); issue(5'b01000, 5'b01000);
    put(0, mk(HEADTAIL, 1, 0, 0, 16'h0001)); route(3, 0); issue(5'b00000, 5'b01000);
    put(4, mk(HEADTAIL, 2, 3, 3, 16'h4008)); route(3, 4); issue(5'b01000, 5'b01000);
    put(0, mk(HEADTAIL, 1, 0, 0, 16'h0002)); route(3, 0); issue(5'b01000, 5'b01000);

`ifdef XBAR_STATS_EN
    pulse_reset();
    for (int k = 0; k < 20; k++) begin
      put(0, mk(HEADTAIL, 0, 1, 1, 16'h5000 + 16'(k)));
      route(0, 0);
      issue(5'b00001, 5'b00000);
    end
    repeat (3) @(negedge clk);
    check("flit_cnt_o[0]", 32'(flit_cnt_o[0]), 32'd15);
`endif

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crossbar_st.md
Name: crossbar_st

Overview:
- Registered, packet-aware switch-traversal crossbar for the NoC router.
- Each output takes a per-cycle select from the switch allocator and forwards the chosen input flit after exactly one cycle.
- Each output keeps a HEAD-to-TAIL packet lock so it cannot interleave packets, and flags protocol violations.
- Sits between the input ports' VC buffers and the output links; replaces the purely combinational crossbar.

Parameters:
- INPUT_NUM, 5: number of input ports.
- OUTPUT_NUM, 5: number of output ports.
- SEL_SIZE, $clog2(INPUT_NUM): select width (derived localparam, not overridable).
- CNT_W, 16: width of per-output flit counters (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_i  input  flit_t [INPUT_NUM]  input flits.
- valid_i  input  [INPUT_NUM]  flit present on data_i[i].
- sel_i  input  [SEL_SIZE] x [OUTPUT_NUM]  input index granted to each output.
- sel_valid_i  input  [OUTPUT_NUM]  grant for output o is active this cycle.
- data_o  output  flit_t [OUTPUT_NUM]  registered output flits.
- valid_o  output  [OUTPUT_NUM]  data_o[o] carries a new flit this cycle.
- error_o  output  [OUTPUT_NUM]  sticky protocol error per output.
- flit_cnt_o  output  [CNT_W] x [OUTPUT_NUM]  forwarded-flit count; present only with XBAR_STATS_EN.

Behaviour:
- Reset (rst=0, asynchronous): data_o = all-zero flit; valid_o = 0; error_o = 0; every output FSM in IDLE; owner = 0; flit_cnt_o = 0.
- Request: req[o] = sel_valid_i[o] & (sel_i[o] < INPUT_NUM) & valid_i[sel_i[o]].
- Bad select: sel_valid_i[o]=1 with sel_i[o] >= INPUT_NUM gives no forward and sets error_o[o] at the next edge.
- Latency: a forwarded flit appears on data_o[o], with valid_o[o]=1, exactly 1 cycle after the request.
- No forward: valid_o[o]=0 and data_o[o] holds its previous value.
- No backpressure inside the block; the allocator guarantees downstream credit.
- Per-output FSM, states IDLE and BUSY; owner register of width SEL_SIZE. Transitions on req[o], by flit_label:
  - IDLE + HEAD: forward; owner <= sel; go to BUSY.
  - IDLE + HEADTAIL: forward; stay IDLE.
  - IDLE + BODY or TAIL: forward; set error; stay IDLE.
  - BUSY, sel == owner, BODY: forward; stay BUSY.
  - BUSY, sel == owner, TAIL: forward; go to IDLE.
  - BUSY, sel == owner, HEAD or HEADTAIL: forward; set error. HEAD stays BUSY with owner unchanged; HEADTAIL goes to IDLE.
  - BUSY, sel != owner, any label: drop (valid_o=0); set error; state unchanged.
- Multicast is legal: one input selected by several outputs in the same cycle is forwarded to each of them independently.
- error_o is sticky until reset.
- Reset asserted mid-packet aborts the lock immediately; no flit is emitted during or after reset until a new request.
- Flit fields pass through unmodified, vc_id included.

Optional Feature:
- Macro: XBAR_STATS_EN.
- Defined: flit_cnt_o[o] increments by 1 on every cycle valid_o[o] is asserted for the next cycle (i.e. per forwarded flit). Saturates at 2^CNT_W-1, no wrap. Reset to 0.
- Undefined: flit_cnt_o port and counters are absent; all other behaviour is identical.

Decomposition:
- noc_params holds flit_t and flit_label_t (existing) plus new xbar_state_t enum {IDLE, BUSY}.
- Sub-module crossbar_st_port: one output's mux, request logic, FSM, owner register, output register, error flag and optional counter. Generated OUTPUT_NUM times.
- The top level handles only fan-out of data_i, valid_i and the selects.

Test Plan:
1. Reset, then out[o] selects in[o] with a HEADTAIL flit (vc_id=1, x_dest=1, y_dest=1) on all inputs -> one cycle later data_o[o] == data_i[o], valid_o=1111...; error_o=0.
2. Out2 gets HEAD, BODY, BODY, TAIL from in3 over 4 cycles; in cycle 2, out2 also selects in1 (BODY) -> in1 flit dropped; valid_o[2]=0 that cycle; error_o[2]=1; in3 packet completes; FSM returns to IDLE.
3. Out0 and out4 both select in1 with HEADTAIL -> both outputs carry the identical flit one cycle later; no errors.
4. sel_valid_i[1]=1, sel_i[1]=7 with INPUT_NUM=5 -> valid_o[1]=0, error_o[1]=1; out1 FSM stays IDLE.
5. rst pulsed low after HEAD and BODY on out3 -> outputs clear asynchronously. A following BODY on out3 sets error_o[3] (IDLE + BODY); a following HEAD instead is accepted cleanly.
6. XBAR_STATS_EN with CNT_W=4: 20 consecutive HEADTAIL flits on out0 -> flit_cnt_o[0] reads 15 and holds.
